// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler_if
//  Description : Bus bundle between the pipeline (writeback, decode, MDU) and
//                the register-file write-port scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if;
  logic        WbValid;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        IssueValid;
  logic [4:0]  IssueAddr;
  logic        IssueReady;
  logic        MduValid;
  logic [4:0]  MduAddr;
  logic [31:0] MduData;
  logic        MduReady;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic        Stall;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        WawErr;

  // Pipeline side: drives requests, observes the scheduler decisions.
  modport master (
    output WbValid, WbAddr, WbData, IssueValid, IssueAddr,
           MduValid, MduAddr, MduData, RsAddr, RtAddr,
    input  IssueReady, MduReady, Stall, RegWrite, WriteAddr, WriteData, WawErr
  );

  // Scheduler side.
  modport slave (
    input  WbValid, WbAddr, WbData, IssueValid, IssueAddr,
           MduValid, MduAddr, MduData, RsAddr, RtAddr,
    output IssueReady, MduReady, Stall, RegWrite, WriteAddr, WriteData, WawErr
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler
//  Description : Shares the single register-file write port between the
//                writeback stage and the MDU, buffers MDU results in a small
//                FIFO and keeps a pending-result scoreboard for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [31:0]      pending;
  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        fifo_empty;
  logic        mdu_ready;
  logic        mdu_fire;
  logic        mdu_nonzero;
  logic        issue_ready;
  logic        issue_fire;
  logic        do_pop;
  logic        do_bypass;
  logic        do_push;
  logic        clear_en;
  logic [4:0]  clear_addr;
  logic [31:0] pending_next;

  assign fifo_empty  = (count == '0);
  // Full FIFO refuses a result even if the head drains this cycle.
  assign mdu_ready   = ~reset & (count < FULL_COUNT);
  assign mdu_fire    = bus.MduValid & mdu_ready;
  assign mdu_nonzero = (bus.MduAddr != 5'd0);

  // A register whose clear lands this edge still reads pending, so a
  // re-issue to it is refused for one more cycle.
  assign issue_ready = ~reset & ((bus.IssueAddr == 5'd0) | ~pending[bus.IssueAddr]);
  assign issue_fire  = bus.IssueValid & issue_ready;

  // Writeback owns the port; buffered results drain before a bypass.
  assign do_pop     = ~reset & ~bus.WbValid & ~fifo_empty;
  assign do_bypass  = ~reset & ~bus.WbValid & fifo_empty & mdu_fire & mdu_nonzero;
  assign do_push    = mdu_fire & mdu_nonzero & ~do_bypass;
  assign clear_en   = do_pop | do_bypass;
  assign clear_addr = do_pop ? fifo_addr[rd_ptr] : bus.MduAddr;

  assign bus.IssueReady = issue_ready;
  assign bus.MduReady   = mdu_ready;
  assign bus.Stall      = ~reset &
                          (((bus.RsAddr != 5'd0) & pending[bus.RsAddr]) |
                           ((bus.RtAddr != 5'd0) & pending[bus.RtAddr]));
  assign bus.WawErr     = ~reset & bus.WbValid & (bus.WbAddr != 5'd0) & pending[bus.WbAddr];

  // Write-port select: writeback, then FIFO head, then direct MDU bypass.
  always_comb begin
    bus.RegWrite  = 1'b0;
    bus.WriteAddr = 5'd0;
    bus.WriteData = 32'd0;
    if (!reset) begin
      if (bus.WbValid) begin
        bus.RegWrite  = 1'b1;
        bus.WriteAddr = bus.WbAddr;
        bus.WriteData = bus.WbData;
      end else if (!fifo_empty) begin
        bus.RegWrite  = 1'b1;
        bus.WriteAddr = fifo_addr[rd_ptr];
        bus.WriteData = fifo_data[rd_ptr];
      end else if (do_bypass) begin
        bus.RegWrite  = 1'b1;
        bus.WriteAddr = bus.MduAddr;
        bus.WriteData = bus.MduData;
      end
    end
  end

  // Scoreboard next state: clear on MDU write, set on accepted issue.
  always_comb begin
    pending_next = pending;
    if (clear_en) begin
      pending_next[clear_addr] = 1'b0;
    end
    if (issue_fire && (bus.IssueAddr != 5'd0)) begin
      pending_next[bus.IssueAddr] = 1'b1;
    end
  end

  // Scoreboard, FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      pending <= pending_next;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= bus.MduAddr;
      fifo_data[wr_ptr] <= bus.MduData;
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and scoreboard for the 32x32 register file (two read ports, one write port, register 0 reads as zero) in the pipeline CPU. It shares the single write port between the in-order writeback stage and a multi-cycle multiply/divide unit (MDU). It buffers MDU results in a small FIFO while the port is busy. It tracks registers with an outstanding MDU result so decode can stall on RAW/WAW hazards.

## Interface
Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- WbValid  in  1  writeback stage wants to write this cycle
- WbAddr  in  5  writeback destination
- WbData  in  32  writeback data
- IssueValid  in  1  decode issuing an MDU op this cycle
- IssueAddr  in  5  MDU op destination register
- IssueReady  out  1  issue accepted (fires on IssueValid & IssueReady)
- MduValid  in  1  MDU result available
- MduAddr  in  5  MDU result destination
- MduData  in  32  MDU result
- MduReady  out  1  scheduler can accept MDU result (fires on MduValid & MduReady)
- RsAddr, RtAddr  in  5 each  decode source registers
- Stall  out  1  a decode source register has a pending MDU result
- RegWrite  out  1  register file write enable
- WriteAddr  out  5  register file write address
- WriteData  out  32  register file write data
- WawErr  out  1  one-cycle pulse: writeback targeted a pending register

## Operation
- State: pending[31:0] scoreboard; FIFO of {addr, data}, DEPTH entries with rd/wr pointers and a count.
- Issue: IssueReady = (IssueAddr == 0) | ~pending[IssueAddr]. On an accepted issue with IssueAddr != 0, pending[IssueAddr] is set.
- MDU accept: MduReady = (count < DEPTH). A result with MduAddr == 0 is accepted and discarded: no FIFO entry, no write.
- Write-port priority, highest first:
  1. WbValid: writes WbAddr/WbData. Writeback is never stalled.
  2. FIFO non-empty: writes the FIFO head and pops it.
  3. Bypass: FIFO empty and an MDU result is accepted this cycle with a nonzero address. The result is written directly and not enqueued.
- An accepted MDU result that is neither written nor discarded is enqueued. A push and a pop may occur in the same cycle; count is unchanged.
- When an MDU result is written (via FIFO pop or bypass), pending[addr] clears at the next edge.
- Stall = (RsAddr != 0 & pending[RsAddr]) | (RtAddr != 0 & pending[RtAddr]).
- WawErr = WbValid & WbAddr != 0 & pending[WbAddr]. The write still proceeds; WawErr only flags it.
- WbAddr == 0 is passed through unchanged; the register file masks register 0 on reads.

## Timing
- RegWrite/WriteAddr/WriteData, IssueReady, MduReady, Stall and WawErr are combinational from inputs and registered state. The register file captures the write on the same edge.
- Reset:
  - pending clears, FIFO empties, pointers and count go to 0.
  - While reset is high: RegWrite=0, WriteAddr=0, WriteData=0, IssueReady=0, MduReady=0, Stall=0, WawErr=0.
  - Reset mid-operation discards buffered MDU results and pending bits.
- Latency:
  - An MDU result with the port free is written in its accept cycle (0 cycles).
  - Otherwise it is written in the first cycle with WbValid=0, in FIFO order.
- Scoreboard timing:
  - Stall deasserts the cycle after the result's write edge; the register file already holds the data then.
  - An issue to a register whose clear happens in the same cycle is refused (IssueReady=0) and succeeds the next cycle.
- FIFO full: MduReady=0 even if a pop occurs that cycle; no push at full.
- Pointers wrap modulo DEPTH.

## Test plan
- Bypass: FIFO empty, WbValid=0, issue r5, then MduValid with r5=0x1234. Required: RegWrite=1, WriteAddr=5, WriteData=0x1234 in the accept cycle; Stall with RsAddr=5 high until that edge, low the next cycle.
- Contention: WbValid held 3 cycles while MDU delivers r7=0xA, then r8=0xB. Required: MduReady=0 on the third attempt (FIFO full). After WbValid drops, writes r7 then r8 on consecutive cycles, each followed by its pending clear.
- Issue to r9 while pending[r9]=1. Required: IssueReady=0. After r9's result is written, IssueReady=1 the next cycle.
- Zero register: issue with IssueAddr=0 leaves Stall low. An MDU result to r0 is accepted with RegWrite=0. WbValid with WbAddr=0 writes through with WawErr=0.
- WAW: pending[r3]=1 and WbValid, WbAddr=3, WbData=0x55. Required: WawErr=1 for one cycle, register file write of 0x55 to r3, pending[r3] still 1.
- Reset with 2 FIFO entries and pending bits set. Required: next cycle FIFO empty, Stall=0, RegWrite=0; no buffered result is written afterwards.
